// File: rtl/riscv_fetch_buffer_pkg.sv
// Shared types for the instruction prefetch stage.
// Holds the fetch FSM states, FIFO entry layout and address helpers.
package riscv_fetch_buffer_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_WAIT,
    FETCH_DROP
  } fetch_state_e;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/riscv_fetch_buffer_fifo.sv
// Small synchronous FIFO of {pc, instr} entries for the prefetch stage.
// Ports: clk, rst (async clear), flush, push/wdata, pop, valid/head, count.
import riscv_fetch_buffer_pkg::*;

module riscv_fetch_buffer_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  fetch_entry_t             wdata,
  output logic                     valid,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign valid   = count != '0;
  assign do_push = push && !flush;
  assign do_pop  = pop && valid;

  // Head reads as zero while empty so stale storage never leaks out.
  assign head = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Requests are only issued with room reserved, so a push into a
  // full FIFO means the fetch FSM lost track of occupancy.
  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    do_push |-> (count < CW'(DEPTH))
  );

endmodule

// File: rtl/riscv_fetch_buffer.sv
// Instruction prefetch stage: fetches words over req/ack, buffers them
// with their PC and hands them to decode; redirect flushes and restarts.
// Ports: clk, rst, redirect/redirect_pc, mem_req/mem_addr/mem_ack/
// mem_rdata, instr_valid/instr/instr_pc/instr_ready.
import riscv_fetch_buffer_pkg::*;

module riscv_fetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e  state;
  fetch_state_e  state_n;
  logic [31:0]   next_pc;
  logic [31:0]   next_pc_n;
  logic [31:0]   req_addr;
  logic [31:0]   req_addr_n;
  logic [31:0]   target;
  logic [31:0]   seq_addr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          push;
  logic          pop;
  logic          room;
  fetch_entry_t  wdata;
  fetch_entry_t  head;

  assign target     = word_align(redirect_pc);
  assign seq_addr   = req_addr + INSTR_BYTES;
  assign pop        = instr_valid && instr_ready;
  assign push       = (state == FETCH_WAIT) && mem_ack && !redirect;
  assign count_next = count + CW'(push) - CW'(pop);
  assign room       = count_next < CW'(DEPTH);

  assign mem_req  = (state == FETCH_WAIT) || (state == FETCH_DROP);
  assign mem_addr = req_addr;
  assign wdata    = '{pc: req_addr, instr: mem_rdata};
  assign instr    = head.instr;
  assign instr_pc = head.pc;

  riscv_fetch_buffer_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .valid (instr_valid),
    .head  (head),
    .count (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH_IDLE;
      next_pc  <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state    <= state_n;
      next_pc  <= next_pc_n;
      req_addr <= req_addr_n;
    end
  end

  always_comb begin
    state_n    = state;
    next_pc_n  = next_pc;
    req_addr_n = req_addr;
    unique case (state)
      FETCH_IDLE: begin
        if (redirect) begin
          next_pc_n = target;
        end else if (room) begin
          req_addr_n = next_pc;
          state_n    = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (mem_ack && redirect) begin
          next_pc_n = target;
          state_n   = FETCH_IDLE;
        end else if (mem_ack) begin
          // Stream back-to-back while the word just pushed leaves room.
          next_pc_n = seq_addr;
          if (room) begin
            req_addr_n = seq_addr;
          end else begin
            state_n = FETCH_IDLE;
          end
        end else if (redirect) begin
          // Request is in flight; keep it stable and discard its data.
          next_pc_n = target;
          state_n   = FETCH_DROP;
        end
      end
      FETCH_DROP: begin
        if (redirect) begin
          next_pc_n = target;
        end
        if (mem_ack) begin
          state_n = FETCH_IDLE;
        end
      end
      default: begin
        state_n = FETCH_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_riscv_fetch_buffer.sv
// Self-checking bench for riscv_fetch_buffer: memory model, scoreboard
// and monitor, directed scenarios then randomized traffic.
module tb_riscv_fetch_buffer;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;

  riscv_fetch_buffer #(
    .DEPTH(DEPTH),
    .RESET_PC(RPC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          lat_min = 0;
  int          lat_max = 0;
  int          ready_pct = 100;
  int          redir_pct = 0;
  bit          ready_once = 0;
  bit          force_redir = 0;
  logic [31:0] force_tgt = '0;
  bit          busy = 0;
  int          wait_left = 0;
  int          epoch = 0;
  int          req_epoch = 0;
  logic [31:0] req_addr = '0;
  logic [31:0] fetch_exp = RPC;
  int          nacks = 0;
  int          delivered = 0;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%b want=%b t=%0t", name, act, exp, $time);
    end
  endtask

  // Memory model and stimulus: one request outstanding, variable latency.
  // A request started before the latest redirect is stale: its data
  // must never reach decode.
  always @(negedge clk) begin
    if (rst) begin
      redirect    = 1'b0;
      mem_ack     = 1'b0;
      instr_ready = 1'b0;
      busy        = 0;
    end else begin
      redirect = force_redir || ($urandom_range(99) < redir_pct);
      if (force_redir) redirect_pc = force_tgt;
      else if ($urandom_range(3) == 0)
        redirect_pc = 32'hFFFF_FFF0 + $urandom_range(15);
      else redirect_pc = $urandom_range(32'hFFFF);
      force_redir = 0;
      instr_ready = ready_once || ($urandom_range(99) < ready_pct);
      ready_once = 0;
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      if (busy) begin
        chk1("req_hold", mem_req, 1'b1);
        chk("addr_hold", mem_addr, req_addr);
      end
      if (mem_req) begin
        if (!busy) begin
          busy = 1;
          req_addr = mem_addr;
          req_epoch = epoch;
          wait_left = $urandom_range(lat_max, lat_min);
          chk("fetch_addr", mem_addr, fetch_exp);
          chk1("room_at_req", sb.size() < DEPTH, 1'b1);
        end
        if (wait_left == 0) begin
          mem_ack = 1'b1;
          mem_rdata = memw(mem_addr);
          busy = 0;
          nacks++;
          if (!redirect && req_epoch == epoch) begin
            sb.push_back('{pc: mem_addr, ins: memw(mem_addr)});
            fetch_exp = mem_addr + 32'd4;
          end
        end else begin
          wait_left--;
        end
      end
      if (redirect) begin
        epoch++;
        fetch_exp = redirect_pc & ~32'h3;
      end
    end
  end

  // Monitor: compares every consumed word against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!rst) begin
      if (instr_valid && instr_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_instr pc=%h instr=%h", instr_pc, instr);
        end else begin
          e = sb.pop_front();
          chk("instr_pc", instr_pc, e.pc);
          chk("instr", instr, e.ins);
          delivered++;
        end
      end
      if (redirect) sb.delete();
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk1("arst_req", mem_req, 1'b0);
    chk1("arst_valid", instr_valid, 1'b0);
    sb.delete();
    busy = 0;
    epoch++;
    fetch_exp = RPC;
    nacks = 0;
    @(negedge clk);
    #3;
    rst = 1'b0;
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    #1;
    chk1("rst_req", mem_req, 1'b0);
    chk1("rst_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_addr", mem_addr, RPC);
    @(negedge clk);
    #3;
    rst = 1'b0;

    // Zero latency streaming.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #2;
      if (i < 4) begin
        chk1("t1_req", mem_req, 1'b1);
        chk("t1_addr", mem_addr, 32'(4 * i));
      end
      if (i > 0) begin
        chk1("t1_valid", instr_valid, 1'b1);
        chk("t1_pc", instr_pc, 32'(4 * (i - 1)));
      end
    end

    // Three-cycle latency: address held, ack on the third cycle.
    lat_min = 2;
    lat_max = 2;
    @(negedge clk);
    #2;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      #2;
      chk("t2_addr", mem_addr, 32'(4 * (i / 3)));
      chk1("t2_ack", mem_ack, (i % 3) == 2);
    end

    // Fill with decode stalled, then free one slot.
    lat_min = 0;
    lat_max = 0;
    ready_pct = 0;
    @(negedge clk);
    #2;
    do_reset();
    repeat (8) @(negedge clk);
    #2;
    chk("t3_nacks", nacks, 32'd4);
    chk1("t3_req", mem_req, 1'b0);
    chk1("t3_valid", instr_valid, 1'b1);
    ready_once = 1;
    @(negedge clk);
    #2;
    @(negedge clk);
    #2;
    chk1("t3_req2", mem_req, 1'b1);
    chk("t3_addr2", mem_addr, 32'd16);

    // Redirect while a request is waiting.
    lat_min = 2;
    lat_max = 2;
    ready_pct = 100;
    do_reset();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      #2;
      found = mem_req && mem_addr == 32'd4;
    end
    chk1("t4_seen4", found, 1'b1);
    force_redir = 1;
    force_tgt = 32'h0000_000E;
    @(negedge clk);
    #2;
    @(negedge clk);
    #2;
    chk1("t4_valid", instr_valid, 1'b0);
    chk1("t4_drop_req", mem_req, 1'b1);
    chk("t4_drop_addr", mem_addr, 32'd4);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      #2;
      found = mem_req && mem_addr != 32'd4;
    end
    chk1("t4_newreq", found, 1'b1);
    chk("t4_addr", mem_addr, 32'd12);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      #2;
      found = instr_valid;
    end
    chk1("t4_deliver", found, 1'b1);
    chk("t4_pc", instr_pc, 32'd12);

    // Redirect coinciding with ack and pop.
    lat_min = 0;
    lat_max = 0;
    do_reset();
    repeat (4) @(negedge clk);
    #2;
    force_redir = 1;
    force_tgt = 32'h0000_0040;
    @(negedge clk);
    #2;
    chk1("t5_pre_valid", instr_valid, 1'b1);
    chk1("t5_pre_ack", mem_ack, 1'b1);
    @(negedge clk);
    #2;
    chk1("t5_valid", instr_valid, 1'b0);
    chk1("t5_req", mem_req, 1'b0);
    @(negedge clk);
    #2;
    chk1("t5_req2", mem_req, 1'b1);
    chk("t5_addr", mem_addr, 32'h40);
    @(negedge clk);
    #2;
    chk1("t5_valid2", instr_valid, 1'b1);
    chk("t5_pc", instr_pc, 32'h40);

    // Asynchronous reset mid-request with two words buffered.
    lat_min = 2;
    lat_max = 2;
    ready_pct = 0;
    do_reset();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      #2;
      found = sb.size() == 2 && mem_req && !mem_ack;
    end
    chk1("t6_setup", found, 1'b1);
    chk1("t6_valid", instr_valid, 1'b1);
    @(posedge clk);
    #2;
    do_reset();
    @(negedge clk);
    #2;
    chk1("t6_req", mem_req, 1'b1);
    chk("t6_addr", mem_addr, RPC);

    // Randomized traffic.
    lat_min = 0;
    lat_max = 3;
    ready_pct = 60;
    redir_pct = 5;
    repeat (3000) @(negedge clk);
    redir_pct = 0;
    ready_pct = 100;
    repeat (50) @(negedge clk);
    #2;
    chk1("rand_progress", delivered > 300, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
